// File: rtl/uram_rd_pkg.sv
// Shared types and elaboration helpers for the URAM read-stream engine.
package uram_rd_pkg;

    // Burst sequencer states
    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_e;

    // Per-request tag travelling alongside the URAM read latency
    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

    // The output FIFO must hold every in-flight word plus the one at its head,
    // and the tag pipe supports latencies from 1 to 16 cycles.
    function automatic bit fifo_depth_ok(input int unsigned fifo_aw,
                                         input int unsigned latency);
        return (latency >= 1) && (latency <= 16) &&
               ((32'd1 << fifo_aw) >= (latency + 1));
    endfunction

endpackage

// File: rtl/uram_rd_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible while non-empty.
module uram_rd_fifo #(
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned DW      = 33
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [DW-1:0]      wdata_i,
    input  logic               pop_i,
    output logic [DW-1:0]      rdata_o,
    output logic [FIFO_AW:0]   count_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic [DW-1:0]      mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               push_ok;
    logic               pop_ok;

    assign full_o  = (count_q == (FIFO_AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
                2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uram_rd_stream.sv
// Burst reader: issues fixed-latency URAM reads and streams the returned words
// over AXI-Stream, throttling requests so the output FIFO can never overflow.
module uram_rd_stream
    import uram_rd_pkg::*;
#(
    parameter int unsigned MEM_AW      = 8,
    parameter int unsigned MEM_DW      = 32,
    parameter int unsigned MEM_LATENCY = 5,
    parameter int unsigned FIFO_AW     = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [MEM_AW-1:0] addr_i,
    input  logic [MEM_AW:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_en_o,
    output logic [MEM_AW-1:0] mem_r_addr_o,
    input  logic [MEM_DW-1:0] mem_r_data_i,
    output logic [MEM_DW-1:0] m_axis_tdata_o,
    output logic              m_axis_tvalid_o,
    input  logic              m_axis_tready_i,
    output logic              m_axis_tlast_o
);

    localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
    localparam int unsigned IFW        = $clog2(MEM_LATENCY + 1);

    if (!fifo_depth_ok(FIFO_AW, MEM_LATENCY)) begin : g_bad_cfg
        $error("uram_rd_stream: need MEM_LATENCY in 1..16 and 2**FIFO_AW >= MEM_LATENCY+1");
    end

    state_e            state_q;
    logic [MEM_AW-1:0] addr_q;
    logic [MEM_AW:0]   rem_q;
    logic              busy_q;
    logic              done_q;
    tag_t              tag_q [MEM_LATENCY];
    tag_t              tag_out;
    logic [IFW-1:0]    inflight_q;

    logic              issue;
    logic              last_issue;
    logic [31:0]       occupancy;
    logic              fifo_pop;
    logic [MEM_DW:0]   fifo_rdata;
    logic [FIFO_AW:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign tag_out = tag_q[MEM_LATENCY-1];

    // Request gating: every outstanding read already owns a FIFO slot
    always_comb begin
        occupancy  = 32'(fifo_count) + 32'(inflight_q);
        issue      = (state_q == READ) && (rem_q != '0) &&
                     (occupancy < FIFO_DEPTH) && !fifo_full;
        last_issue = issue && (rem_q == (MEM_AW+1)'(1));
    end

    // Burst sequencer with registered busy/done
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q  <= addr_i;
                            rem_q   <= len_i;
                            busy_q  <= 1'b1;
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        addr_q <= addr_q + MEM_AW'(1);
                        rem_q  <= rem_q - (MEM_AW+1)'(1);
                        if (last_issue) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The final-word handshake implies the tag pipe and FIFO are empty
                    if (fifo_pop && fifo_rdata[MEM_DW] && (inflight_q == '0)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag pipe matching the URAM read latency
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: issue, last: last_issue};
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Count of valid tags in the pipe
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= '0;
        end else begin
            case ({issue, tag_out.valid})
                2'b10:   inflight_q <= inflight_q + IFW'(1);
                2'b01:   inflight_q <= inflight_q - IFW'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign fifo_pop = !fifo_empty && m_axis_tready_i;

    uram_rd_fifo #(
        .FIFO_AW (FIFO_AW),
        .DW      (MEM_DW + 1)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tag_out.valid),
        .wdata_i ({tag_out.last, mem_r_data_i}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign mem_en_o        = issue;
    assign mem_r_addr_o    = addr_q;
    assign m_axis_tvalid_o = !fifo_empty;
    assign m_axis_tdata_o  = fifo_empty ? '0 : fifo_rdata[MEM_DW-1:0];
    assign m_axis_tlast_o  = !fifo_empty && fifo_rdata[MEM_DW];

endmodule

// File: tb/tb_uram_rd_stream.sv
// Directed bench for uram_rd_stream with a fixed-latency URAM model (mem[i] = i).
module tb_uram_rd_stream;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 5;
    localparam int unsigned FAW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] addr_i;
    logic [AW:0]   len_i;
    logic          busy_o;
    logic          done_o;
    logic          mem_en_o;
    logic [AW-1:0] mem_r_addr_o;
    logic [DW-1:0] mem_r_data_i;
    logic [DW-1:0] m_axis_tdata_o;
    logic          m_axis_tvalid_o;
    logic          m_axis_tready_i;
    logic          m_axis_tlast_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    uram_rd_stream #(
        .MEM_AW      (AW),
        .MEM_DW      (DW),
        .MEM_LATENCY (LAT),
        .FIFO_AW     (FAW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .addr_i          (addr_i),
        .len_i           (len_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .mem_en_o        (mem_en_o),
        .mem_r_addr_o    (mem_r_addr_o),
        .mem_r_data_i    (mem_r_data_i),
        .m_axis_tdata_o  (m_axis_tdata_o),
        .m_axis_tvalid_o (m_axis_tvalid_o),
        .m_axis_tready_i (m_axis_tready_i),
        .m_axis_tlast_o  (m_axis_tlast_o)
    );

    // URAM model: content mem[i] = i, data appears LAT cycles after the address
    logic [DW-1:0] mem [256];
    logic [AW-1:0] apipe [LAT];
    always @(posedge clk_i) begin
        apipe[0] <= mem_r_addr_o;
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign mem_r_data_i = mem[apipe[LAT-1]];

    // Observations gathered by run_burst
    int            first_en, first_val, done_k, done_cnt, max_out, en_at30, stab_err;
    logic          busy_k1, busy_at_done;
    logic [AW-1:0] en_addr   [$];
    logic [DW-1:0] beat_data [$];
    logic          beat_last [$];
    int            beat_k    [$];

    // mode 0: tready=1, mode 1: tready toggles 1,0, mode 2: tready=0 for 30 cycles
    task automatic run_burst(input logic [AW-1:0] a, input logic [AW:0] n,
                             input int mode, input int extra_k, input int max_cyc);
        logic          pv, pl, hs;
        logic [DW-1:0] pd;
        int            outst;
        first_en = -1; first_val = -1; done_k = -1; done_cnt = 0;
        max_out = 0; en_at30 = -1; stab_err = 0; busy_k1 = 1'bx; busy_at_done = 1'bx;
        en_addr.delete(); beat_data.delete(); beat_last.delete(); beat_k.delete();
        pv = 1'b0; pl = 1'b0; hs = 1'b0; pd = '0;
        @(negedge clk_i);
        start_i = 1'b1; addr_i = a; len_i = n;
        m_axis_tready_i = (mode == 2) ? 1'b0 : 1'b1;
        @(posedge clk_i);
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk_i);
            start_i = (k == extra_k);
            if (k == extra_k) begin
                addr_i = 8'h80;
                len_i  = 9'd4;
            end
            case (mode)
                1:       m_axis_tready_i = (k % 2 == 1);
                2:       m_axis_tready_i = (k > 30);
                default: m_axis_tready_i = 1'b1;
            endcase
            if (k == 1) busy_k1 = busy_o;
            if (pv && !hs) begin
                if (!m_axis_tvalid_o || m_axis_tdata_o !== pd || m_axis_tlast_o !== pl)
                    stab_err++;
            end
            if (mem_en_o) begin
                en_addr.push_back(mem_r_addr_o);
                if (first_en < 0) first_en = k;
            end
            if (m_axis_tvalid_o) begin
                if (first_val < 0) first_val = k;
                if (m_axis_tready_i) begin
                    beat_data.push_back(m_axis_tdata_o);
                    beat_last.push_back(m_axis_tlast_o);
                    beat_k.push_back(k);
                end
            end
            hs = m_axis_tvalid_o && m_axis_tready_i;
            pv = m_axis_tvalid_o; pd = m_axis_tdata_o; pl = m_axis_tlast_o;
            outst = en_addr.size() - beat_data.size();
            if (outst > max_out) max_out = outst;
            if (k == 30) en_at30 = en_addr.size();
            if (done_o) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k = k;
                    busy_at_done = busy_o;
                end
            end
            if (done_k > 0 && k >= done_k + 3) break;
        end
        start_i = 1'b0;
        m_axis_tready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; addr_i = '0; len_i = '0; m_axis_tready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, mem_en_o, m_axis_tvalid_o, m_axis_tlast_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {busy_o, done_o, mem_en_o, m_axis_tvalid_o, m_axis_tlast_o});
        end
        checks++;
        if (mem_r_addr_o !== '0 || m_axis_tdata_o !== '0) begin
            failures++;
            $display("FAIL reset_data: addr=%0h tdata=%0h expected 0/0", mem_r_addr_o, m_axis_tdata_o);
        end
        rst_i = 1'b0;
        m_axis_tready_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_basic(input string tag);
        run_burst(8'h00, 9'd16, 0, 0, 100);
        checks++;
        if (first_en !== 1) begin failures++; $display("FAIL %s first_en: got %0d expected 1", tag, first_en); end
        checks++;
        if (first_val !== 7) begin failures++; $display("FAIL %s first_tvalid: got %0d expected 7", tag, first_val); end
        checks++;
        if (en_addr.size() !== 16) begin failures++; $display("FAIL %s n_reads: got %0d expected 16", tag, en_addr.size()); end
        checks++;
        if (beat_data.size() !== 16) begin failures++; $display("FAIL %s n_beats: got %0d expected 16", tag, beat_data.size()); end
        for (int i = 0; i < beat_data.size(); i++) begin
            checks++;
            if (beat_data[i] !== DW'(i) || beat_last[i] !== (i == 15) || beat_k[i] !== 7 + i) begin
                failures++;
                $display("FAIL %s beat%0d: data=%0h last=%b cyc=%0d expected %0h %b %0d",
                         tag, i, beat_data[i], beat_last[i], beat_k[i], i, (i == 15), 7 + i);
            end
        end
        checks++;
        if (done_k !== 23 || done_cnt !== 1) begin
            failures++; $display("FAIL %s done: cyc=%0d count=%0d expected 23/1", tag, done_k, done_cnt);
        end
        checks++;
        if (busy_k1 !== 1'b1 || busy_at_done !== 1'b0) begin
            failures++; $display("FAIL %s busy: k1=%b at_done=%b expected 1/0", tag, busy_k1, busy_at_done);
        end
        checks++;
        if (stab_err !== 0) begin failures++; $display("FAIL %s axis_hold: got %0d expected 0", tag, stab_err); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea;
        run_burst(8'hFC, 9'd8, 0, 0, 100);
        checks++;
        if (en_addr.size() !== 8 || beat_data.size() !== 8) begin
            failures++;
            $display("FAIL wrap_counts: reads=%0d beats=%0d expected 8/8", en_addr.size(), beat_data.size());
        end
        for (int i = 0; i < en_addr.size(); i++) begin
            ea = 8'hFC + 8'(i);
            checks++;
            if (en_addr[i] !== ea) begin
                failures++; $display("FAIL wrap_addr%0d: got %0h expected %0h", i, en_addr[i], ea);
            end
        end
        for (int i = 0; i < beat_data.size(); i++) begin
            ea = 8'hFC + 8'(i);
            checks++;
            if (beat_data[i] !== DW'(ea) || beat_last[i] !== (i == 7)) begin
                failures++;
                $display("FAIL wrap_beat%0d: data=%0h last=%b expected %0h %b", i, beat_data[i], beat_last[i], ea, (i == 7));
            end
        end
        checks++;
        if (done_k !== 15) begin failures++; $display("FAIL wrap_done: got %0d expected 15", done_k); end
    endtask

    task automatic test_toggle_ready();
        run_burst(8'h00, 9'd16, 1, 0, 200);
        checks++;
        if (beat_data.size() !== 16 || en_addr.size() !== 16) begin
            failures++;
            $display("FAIL toggle_counts: beats=%0d reads=%0d expected 16/16", beat_data.size(), en_addr.size());
        end
        for (int i = 0; i < beat_data.size(); i++) begin
            checks++;
            if (beat_data[i] !== DW'(i) || beat_last[i] !== (i == 15)) begin
                failures++;
                $display("FAIL toggle_beat%0d: data=%0h last=%b expected %0h %b", i, beat_data[i], beat_last[i], i, (i == 15));
            end
        end
        checks++;
        if (max_out > 8) begin failures++; $display("FAIL toggle_outstanding: got %0d expected <=8", max_out); end
        checks++;
        if (beat_k.size() == 0 || done_k !== beat_k[beat_k.size()-1] + 1 || done_cnt !== 1) begin
            failures++; $display("FAIL toggle_done: got cyc %0d count %0d expected last beat + 1, 1", done_k, done_cnt);
        end
        checks++;
        if (stab_err !== 0) begin failures++; $display("FAIL toggle_axis_hold: got %0d expected 0", stab_err); end
    endtask

    task automatic test_stall();
        run_burst(8'h00, 9'd16, 2, 0, 200);
        checks++;
        if (en_at30 !== 8) begin failures++; $display("FAIL stall_reads_at30: got %0d expected 8", en_at30); end
        checks++;
        if (first_val !== 7) begin failures++; $display("FAIL stall_first_tvalid: got %0d expected 7", first_val); end
        checks++;
        if (beat_data.size() !== 16 || en_addr.size() !== 16) begin
            failures++;
            $display("FAIL stall_counts: beats=%0d reads=%0d expected 16/16", beat_data.size(), en_addr.size());
        end
        for (int i = 0; i < beat_data.size(); i++) begin
            checks++;
            if (beat_data[i] !== DW'(i) || beat_k[i] !== 31 + i) begin
                failures++;
                $display("FAIL stall_beat%0d: data=%0h cyc=%0d expected %0h %0d", i, beat_data[i], beat_k[i], i, 31 + i);
            end
        end
        checks++;
        if (done_k !== 47) begin failures++; $display("FAIL stall_done: got %0d expected 47", done_k); end
        checks++;
        if (stab_err !== 0 || max_out > 8) begin
            failures++; $display("FAIL stall_hold: hold_err=%0d outstanding=%0d expected 0/<=8", stab_err, max_out);
        end
    endtask

    task automatic test_len0_and_ignore();
        run_burst(8'h10, 9'd0, 0, 0, 20);
        checks++;
        if (done_k !== 1 || done_cnt !== 1) begin
            failures++; $display("FAIL len0_done: cyc=%0d count=%0d expected 1/1", done_k, done_cnt);
        end
        checks++;
        if (en_addr.size() !== 0 || first_val !== -1 || busy_k1 !== 1'b0) begin
            failures++;
            $display("FAIL len0_quiet: reads=%0d first_tvalid=%0d busy=%b expected 0/-1/0", en_addr.size(), first_val, busy_k1);
        end
        run_burst(8'h00, 9'd16, 0, 5, 100);
        checks++;
        if (en_addr.size() !== 16 || beat_data.size() !== 16) begin
            failures++;
            $display("FAIL ignore_counts: reads=%0d beats=%0d expected 16/16", en_addr.size(), beat_data.size());
        end
        for (int i = 0; i < en_addr.size(); i++) begin
            checks++;
            if (en_addr[i] !== AW'(i)) begin
                failures++; $display("FAIL ignore_addr%0d: got %0h expected %0h", i, en_addr[i], i);
            end
        end
        for (int i = 0; i < beat_data.size(); i++) begin
            checks++;
            if (beat_data[i] !== DW'(i)) begin
                failures++; $display("FAIL ignore_beat%0d: got %0h expected %0h", i, beat_data[i], i);
            end
        end
        checks++;
        if (done_k !== 23 || done_cnt !== 1) begin
            failures++; $display("FAIL ignore_done: cyc=%0d count=%0d expected 23/1", done_k, done_cnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n_en, stray;
        n_en = 0; stray = 0;
        @(negedge clk_i);
        start_i = 1'b1; addr_i = 8'h00; len_i = 9'd16; m_axis_tready_i = 1'b1;
        @(posedge clk_i);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (mem_en_o) n_en++;
        end
        rst_i = 1'b1;
        checks++;
        if (n_en !== 4) begin failures++; $display("FAIL midrst_inflight: got %0d expected 4", n_en); end
        @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, mem_en_o, m_axis_tvalid_o, m_axis_tlast_o} !== 5'b0 ||
            mem_r_addr_o !== '0 || m_axis_tdata_o !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: ctrl=%b addr=%0h tdata=%0h expected 0",
                     {busy_o, done_o, mem_en_o, m_axis_tvalid_o, m_axis_tlast_o}, mem_r_addr_o, m_axis_tdata_o);
        end
        rst_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (m_axis_tvalid_o || mem_en_o || done_o || busy_o) stray++;
        end
        checks++;
        if (stray !== 0) begin failures++; $display("FAIL midrst_stale: got %0d active cycles expected 0", stray); end
        test_basic("after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DW'(i);
        test_reset();
        test_basic("basic");
        test_wrap();
        test_toggle_ready();
        test_stall();
        test_len0_and_ignore();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uram_rd_stream.md
Name: uram_rd_stream

Overview:
Read-side companion to the URAM_SC memory family. Accepts a burst command (start address, word count) and issues single-port read requests to an external fixed-latency URAM. Returned words are streamed out on an AXI-Stream master with full backpressure support. It sits between a URAM instance and any stream consumer (DMA, DAC feeder, readout engine), and drains memory contents that a writer filled earlier.

Parameters:
MEM_AW, 8, URAM address width; memory depth 2**MEM_AW words
MEM_DW, 32, URAM and stream data width
MEM_LATENCY, 5, clock cycles from mem_en_o/mem_r_addr_o to valid mem_r_data_i; legal range 1..16
FIFO_AW, 3, output FIFO address width; elaboration must fail unless 2**FIFO_AW >= MEM_LATENCY+1

Ports:
clk_i  in  1  single clock; all logic is rising-edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  command strobe; sampled only in IDLE
addr_i  in  MEM_AW  burst start address
len_i  in  MEM_AW+1  burst length in words, 0..2**MEM_AW
busy_o  out  1  high from accepted start until done_o
done_o  out  1  one-cycle pulse at end of burst
mem_en_o  out  1  read request to URAM
mem_r_addr_o  out  MEM_AW  URAM read address
mem_r_data_i  in  MEM_DW  URAM read data, valid MEM_LATENCY cycles after mem_en_o
m_axis_tdata_o  out  MEM_DW  stream data
m_axis_tvalid_o  out  1  stream valid
m_axis_tready_i  in  1  stream ready
m_axis_tlast_o  out  1  marks final word of burst

Behaviour:
- Reset (rst_i=1 at an edge): all outputs 0, FSM to IDLE, FIFO empty, in-flight tag pipe cleared, counters 0. A reset mid-burst discards all in-flight and buffered data. After reset release, no stale beat may appear.
- FSM states:
  - IDLE: start_i=1 with len_i>0 latches addr/len and goes to READ. start_i=1 with len_i=0 pulses done_o the next cycle, stays IDLE, emits no beats and no mem_en_o.
  - READ: issues reads until the remaining count reaches 0, then goes to DRAIN.
  - DRAIN: waits until the tag pipe is empty and the FIFO is empty, with the last beat handshaken. Then pulses done_o and returns to IDLE.
- start_i while busy_o=1 is ignored. The latched command does not change.
- Read issue: mem_en_o=1 in a cycle iff state=READ, remaining>0 and credit>0, where credit = 2**FIFO_AW − fifo_count − inflight. A read never targets a FIFO slot that could overflow. Backpressure therefore never loses data.
- Address increments by 1 per issued read and wraps modulo 2**MEM_AW (0xFF→0x00 at default).
- Tag pipe: MEM_LATENCY-deep shift of {valid,last}, entered with mem_en_o and the flag for the final read. When the tag emerges, mem_r_data_i is written to the FIFO with its last flag. inflight = popcount of valid tags, maintained as an up/down counter.
- FIFO: first-word-fall-through. m_axis_tvalid_o=1 when non-empty. Pop on tvalid&tready. Simultaneous push and pop in one cycle are allowed, and the count is unchanged.
- AXIS rules: once tvalid_o=1, tdata_o and tlast_o are stable and tvalid_o stays high until the handshake.
- Latency: with start accepted at edge 0 and tready held at 1, the first mem_en_o is in cycle 1. The first tvalid is in cycle 1+MEM_LATENCY+1 (7 at default). Sustained rate is 1 word per clock.
- busy_o rises the cycle after start is accepted. done_o occurs the cycle after the tlast handshake, and busy_o falls together with done_o.
- len_i = 2**MEM_AW reads the whole memory once, starting at addr_i and wrapping.

Decomposition:
- Package uram_rd_pkg holds:
  - the FSM state enum (IDLE, READ, DRAIN)
  - the tag struct {valid, last}
  - a function that checks the FIFO-depth versus latency constraint
- Sub-module uram_rd_fifo: a synchronous FWFT FIFO with parameters FIFO_AW and MEM_DW+1 width (data plus last), and count, full and empty outputs.

Test Plan:
- Memory preloaded mem[i]=i. start addr=0, len=16, tready=1 → first tvalid in cycle 7. Data 0..15 arrives on consecutive cycles, tlast only on 15, done_o one cycle after the last beat.
- addr=0xFC, len=8 → mem_r_addr_o sequence FC,FD,FE,FF,00,01,02,03. The stream carries the same values with tlast on 03.
- len=16 with tready toggling 1,0 every cycle → exactly 16 beats 0..15 in order, none dropped or duplicated. mem_en_o stalls once credit reaches 0, and fifo_count never exceeds 8.
- tready=0 for 30 cycles after start (len=16) → exactly 8 reads are issued, then mem_en_o=0. On tready=1 the remaining words stream out in order.
- start with len=0 → done_o pulses the next cycle, with no mem_en_o and no tvalid. A second start issued during a busy burst is ignored, and the burst completes unchanged.
- rst_i asserted for 1 cycle while 4 words are in flight → all outputs are 0 the next cycle. No tvalid appears for 20 cycles, and a new burst then behaves as in scenario 1.
